// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, state encoding
// and the default operand width.
package calc_pkg;

    localparam int CALC_WIDTH = 16;

    localparam logic [7:0] KEY_ADD = 8'd11;
    localparam logic [7:0] KEY_SUB = 8'd12;
    localparam logic [7:0] KEY_MUL = 8'd13;
    localparam logic [7:0] KEY_DIV = 8'd14;
    localparam logic [7:0] KEY_DEL = 8'd15;
    localparam logic [7:0] KEY_GO  = 8'd16;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHOW    = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [7:0] k);
        return k <= 8'd9;
    endfunction

    function automatic logic is_oper(input logic [7:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Key-event, ALU handshake and display bus of the calculator sequencer.
// master = the sequencer itself, slave = keyboard/ALU/display side.
import calc_pkg::*;

interface calc_sequencer_if #(parameter int WIDTH = CALC_WIDTH) ();
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       op_code;
    logic             alu_start;
    logic             alu_done;
    logic [WIDTH-1:0] alu_r;
    logic [WIDTH-1:0] r;
    logic [1:0]       digits;
    logic [2:0]       state_o;
    logic             done;
    logic             err;

    modport master (
        input  key_valid, key_code, alu_done, alu_r,
        output key_ready, a, b, op_code, alu_start, r, digits, state_o, done, err
    );

    modport slave (
        output key_valid, key_code, alu_done, alu_r,
        input  key_ready, a, b, op_code, alu_start, r, digits, state_o, done, err
    );
endinterface

// File: rtl/bcd_accum.sv
// Decimal operand accumulator: value <= value*10 + d while fewer than
// MAX_DIGITS digits have been taken; supports clear and direct load.
module bcd_accum #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 3,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [CNT_W-1:0] load_count,
    input  logic             add,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] value_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic [WIDTH-1:0] value_next;

    // x*10 built from shifts; overflow simply wraps at WIDTH bits
    assign value_next = (value_reg << 3) + (value_reg << 1) + WIDTH'(digit);
    assign full       = (count_reg >= CNT_W'(MAX_DIGITS));

    // Operand register: clear beats load beats digit append
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            value_reg <= '0;
            count_reg <= '0;
        end else if (load) begin
            value_reg <= load_value;
            count_reg <= load_count;
        end else if (add && !full) begin
            value_reg <= value_next;
            count_reg <= count_reg + 1'b1;
        end
    end

    assign value = value_reg;
    assign count = count_reg;
endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds operands A/B from decimal key events,
// captures the operator, runs the ALU via start/done and holds the result.
// Optional macro CALC_CHAIN_EN: an operator key in SHOW (no error) chains
// the result into A and continues with B entry.
import calc_pkg::*;

module calc_sequencer #(
    parameter int WIDTH      = CALC_WIDTH,
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 255
) (
    input logic              FPGAClk,
    input logic              rst,
    calc_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t state_reg, state_next;

    logic [7:0]       op_reg;
    logic [WIDTH-1:0] r_reg;
    logic             err_reg;
    logic [TMO_W-1:0] tmo_reg;

    // Control strobes from the next-state decoder; index 0 = A, 1 = B
    logic [1:0]       acc_clr, acc_load, acc_add;
    logic [WIDTH-1:0] acc_load_value [2];
    logic [CNT_W-1:0] acc_load_count [2];
    logic [WIDTH-1:0] acc_value      [2];
    logic [CNT_W-1:0] acc_count      [2];
    logic             op_load, op_clr, r_load, r_clr, err_set, err_clr;
    logic             tmo_clr, tmo_inc;
    logic [7:0]       key;

    assign key = bus.key_code;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            bcd_accum #(
                .WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)
            ) u_accum (
                .clk       (FPGAClk),
                .srst      (rst),
                .clr       (acc_clr[gi]),
                .load      (acc_load[gi]),
                .load_value(acc_load_value[gi]),
                .load_count(acc_load_count[gi]),
                .add       (acc_add[gi]),
                .digit     (key[3:0]),
                .value     (acc_value[gi]),
                .count     (acc_count[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge FPGAClk) begin
        if (rst) state_reg <= ST_ENTER_A;
        else     state_reg <= state_next;
    end

    // Next state plus datapath strobes; keys outside ENTER_A/ENTER_B/SHOW fall through unused
    always_comb begin
        state_next        = state_reg;
        acc_clr           = '0;
        acc_load          = '0;
        acc_add           = '0;
        acc_load_value[0] = '0;
        acc_load_value[1] = '0;
        acc_load_count[0] = '0;
        acc_load_count[1] = '0;
        op_load           = 1'b0;
        op_clr            = 1'b0;
        r_load            = 1'b0;
        r_clr             = 1'b0;
        err_set           = 1'b0;
        err_clr           = 1'b0;
        tmo_clr           = 1'b0;
        tmo_inc           = 1'b0;
        case (state_reg)
            ST_ENTER_A, ST_ENTER_B: begin
                if (bus.key_valid) begin
                    if (is_digit(key)) begin
                        acc_add[state_reg == ST_ENTER_B] = 1'b1;
                    end else if (is_oper(key)) begin
                        op_load = 1'b1;
                        if (state_reg == ST_ENTER_A) begin
                            acc_clr[1] = 1'b1;
                            state_next = ST_ENTER_B;
                        end
                    end else if (key == KEY_DEL) begin
                        acc_clr    = 2'b11;
                        op_clr     = 1'b1;
                        r_clr      = 1'b1;
                        err_clr    = 1'b1;
                        state_next = ST_ENTER_A;
                    end else if (key == KEY_GO && state_reg == ST_ENTER_B
                                 && acc_count[1] != '0) begin
                        if (op_reg == KEY_DIV && acc_value[1] == '0) begin
                            err_set    = 1'b1;
                            r_clr      = 1'b1;
                            state_next = ST_SHOW;
                        end else begin
                            state_next = ST_EXEC;
                        end
                    end
                end
            end
            ST_EXEC: begin
                tmo_clr    = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the timeout cycle still delivers its result
                if (bus.alu_done) begin
                    r_load     = 1'b1;
                    state_next = ST_SHOW;
                end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    r_clr      = 1'b1;
                    state_next = ST_SHOW;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_SHOW: begin
                if (bus.key_valid) begin
                    if (is_digit(key)) begin
                        acc_load[0]       = 1'b1;
                        acc_load_value[0] = WIDTH'(key[3:0]);
                        acc_load_count[0] = CNT_W'(1);
                        acc_clr[1]        = 1'b1;
                        op_clr            = 1'b1;
                        err_clr           = 1'b1;
                        state_next        = ST_ENTER_A;
                    end else if (key == KEY_DEL) begin
                        acc_clr    = 2'b11;
                        op_clr     = 1'b1;
                        r_clr      = 1'b1;
                        err_clr    = 1'b1;
                        state_next = ST_ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_oper(key) && !err_reg) begin
                        acc_load[0]       = 1'b1;
                        acc_load_value[0] = r_reg;
                        acc_load_count[0] = '0;
                        acc_clr[1]        = 1'b1;
                        op_load           = 1'b1;
                        state_next        = ST_ENTER_B;
                    end
`endif
                end
            end
            default: state_next = ST_ENTER_A;
        endcase
    end

    // Opcode, result, sticky error and WAIT timeout counter
    always_ff @(posedge FPGAClk) begin
        if (rst) begin
            op_reg  <= '0;
            r_reg   <= '0;
            err_reg <= 1'b0;
            tmo_reg <= '0;
        end else begin
            if (op_clr)       op_reg <= '0;
            else if (op_load) op_reg <= key;
            if (r_clr)        r_reg <= '0;
            else if (r_load)  r_reg <= bus.alu_r;
            if (err_set)      err_reg <= 1'b1;
            else if (err_clr) err_reg <= 1'b0;
            if (tmo_clr)      tmo_reg <= '0;
            else if (tmo_inc) tmo_reg <= tmo_reg + 1'b1;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        bus.key_ready = 1'b0;
        bus.alu_start = 1'b0;
        bus.done      = 1'b0;
        bus.digits    = 2'(acc_count[1]);
        case (state_reg)
            ST_ENTER_A: begin
                bus.key_ready = 1'b1;
                bus.digits    = 2'(acc_count[0]);
            end
            ST_ENTER_B: bus.key_ready = 1'b1;
            ST_EXEC:    bus.alu_start = 1'b1;
            ST_SHOW: begin
                bus.key_ready = 1'b1;
                bus.done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.a       = acc_value[0];
    assign bus.b       = acc_value[1];
    assign bus.op_code = op_reg;
    assign bus.r       = r_reg;
    assign bus.err     = err_reg;
    assign bus.state_o = state_reg;
endmodule
